// File: rtl/cosim_tick_scheduler.sv
// Co-simulation tick scheduler: issues one HDL-to-SystemC tick request every
// P clocks. Each request is held until it is acknowledged. The block counts
// completed handshakes against an optional budget and reports stalls,
// overruns and protocol errors.
module cosim_tick_scheduler #(
    parameter int CNT_W  = 16,
    parameter int TICK_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [TICK_W-1:0] cfg_budget,
    input  logic              tick_ack,
    output logic              tick_req,
    output logic              busy,
    output logic              done,
    output logic [TICK_W-1:0] tick_count,
    output logic [TICK_W-1:0] stall_cycles,
    output logic              overrun,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;        // period countdown
    logic [CNT_W-1:0]    per_q, per_d;        // latched effective period P
    logic [TICK_W-1:0]   bud_q, bud_d;        // latched budget B
    logic [CNT_W-1:0]    wait_q, wait_d;      // stalled cycles of the current handshake
    logic                stop_pend_q, stop_pend_d;
    logic [TICK_W-1:0]   count_q, count_d;
    logic [TICK_W-1:0]   stall_q, stall_d;
    logic                overrun_q, overrun_d;
    logic                proto_q, proto_d;
    logic                tick_req_q, busy_q, done_q;

    logic [CNT_W-1:0]    eff_period_s;
    logic [TICK_W-1:0]   count_inc_s;
    logic [CNT_W:0]      wait_next_s;

    // Next-state, counter and sticky-flag logic for the scheduler FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        per_d       = per_q;
        bud_d       = bud_q;
        wait_d      = wait_q;
        stop_pend_d = stop_pend_q;
        count_d     = count_q;
        stall_d     = stall_q;
        overrun_d   = overrun_q;
        // An acknowledge outside a request window is a protocol error.
        proto_d     = proto_q | (tick_ack & (state_q != ST_REQ));

        if (cfg_period == {CNT_W{1'b0}}) begin
            eff_period_s = CNT_W'(1);
        end else begin
            eff_period_s = cfg_period;
        end
        count_inc_s = count_q + TICK_W'(1);
        wait_next_s = {1'b0, wait_q} + (CNT_W + 1)'(1);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    per_d       = eff_period_s;
                    bud_d       = cfg_budget;
                    count_d     = {TICK_W{1'b0}};
                    stall_d     = {TICK_W{1'b0}};
                    overrun_d   = 1'b0;
                    proto_d     = tick_ack;
                    stop_pend_d = 1'b0;
                    wait_d      = {CNT_W{1'b0}};
                    // The start cycle itself is the first clock of the period,
                    // so the request rises exactly P clocks after start.
                    if (eff_period_s == CNT_W'(1)) begin
                        state_d = ST_REQ;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = eff_period_s - CNT_W'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    cnt_d = cnt_q;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_REQ;
                    cnt_d   = {CNT_W{1'b0}};
                    wait_d  = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_REQ: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end else begin
                    stop_pend_d = stop_pend_q;
                end
                if (tick_ack) begin
                    count_d     = count_inc_s;
                    stop_pend_d = 1'b0;
                    if (stop_pend_q || stop) begin
                        state_d = ST_IDLE;
                    end else if ((bud_q != {TICK_W{1'b0}}) && (count_inc_s == bud_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = per_q;
                    end
                end else begin
                    if (stall_q != {TICK_W{1'b1}}) begin
                        stall_d = stall_q + TICK_W'(1);
                    end else begin
                        stall_d = stall_q;
                    end
                    if (wait_q != {CNT_W{1'b1}}) begin
                        wait_d = wait_q + CNT_W'(1);
                    end else begin
                        wait_d = wait_q;
                    end
                    if (wait_next_s >= {1'b0, per_q}) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any run at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            per_q       <= {CNT_W{1'b0}};
            bud_q       <= {TICK_W{1'b0}};
            wait_q      <= {CNT_W{1'b0}};
            stop_pend_q <= 1'b0;
            count_q     <= {TICK_W{1'b0}};
            stall_q     <= {TICK_W{1'b0}};
            overrun_q   <= 1'b0;
            proto_q     <= 1'b0;
            tick_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            bud_q       <= bud_d;
            wait_q      <= wait_d;
            stop_pend_q <= stop_pend_d;
            count_q     <= count_d;
            stall_q     <= stall_d;
            overrun_q   <= overrun_d;
            proto_q     <= proto_d;
            tick_req_q  <= (state_d == ST_REQ);
            busy_q      <= (state_d == ST_WAIT) || (state_d == ST_REQ);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign tick_req     = tick_req_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign tick_count   = count_q;
    assign stall_cycles = stall_q;
    assign overrun      = overrun_q;
    assign proto_err    = proto_q;

endmodule

// File: tb/tb_cosim_tick_scheduler.sv
// Self-checking bench for cosim_tick_scheduler: a vector table for the
// tied-ack runs, hand sequences for stall/pause/stop/reset corners, and a
// randomized phase against a behavioural model.
module tb_cosim_tick_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, pause, tick_ack;
    logic [15:0] cfg_period;
    logic [31:0] cfg_budget;
    logic        tick_req, busy, done, overrun, proto_err;
    logic [31:0] tick_count, stall_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cosim_tick_scheduler #(.CNT_W(16), .TICK_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .cfg_period   (cfg_period),
        .cfg_budget   (cfg_budget),
        .tick_ack     (tick_ack),
        .tick_req     (tick_req),
        .busy         (busy),
        .done         (done),
        .tick_count   (tick_count),
        .stall_cycles (stall_cycles),
        .overrun      (overrun),
        .proto_err    (proto_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 1'b0; stop = 1'b0; pause = 1'b0; tick_ack = 1'b0;
    endtask

    typedef struct {
        logic        s, sp, pa, a;
        logic [15:0] per;
        logic [31:0] bud;
        logic        e_req, e_busy, e_done;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic sp, input logic pa, input logic a,
                                input logic [15:0] per, input logic [31:0] bud,
                                input logic er, input logic eb, input logic ed,
                                input logic [31:0] ec);
        vec_t v;
        v.s = s; v.sp = sp; v.pa = pa; v.a = a; v.per = per; v.bud = bud;
        v.e_req = er; v.e_busy = eb; v.e_done = ed; v.e_cnt = ec;
        return v;
    endfunction

    // Behavioural reference: run/request flags plus "clocks left before the
    // next request", advanced once per clock from the spec rules.
    logic        m_active, m_req, m_done, m_pend, m_ovr, m_perr;
    int          m_left, m_wait, m_P;
    logic [31:0] m_B, m_cnt;
    longint      m_stall;

    task automatic model_reset();
        m_active = 1'b0; m_req = 1'b0; m_done = 1'b0; m_pend = 1'b0;
        m_ovr = 1'b0; m_perr = 1'b0; m_left = 0; m_wait = 0; m_P = 0;
        m_B = 32'd0; m_cnt = 32'd0; m_stall = 0;
    endtask

    task automatic model_step(input logic s, input logic sp, input logic pa, input logic a,
                              input logic [15:0] per, input logic [31:0] bud);
        logic req_was;
        req_was = m_req;
        if (!m_active) begin
            if (s) begin
                m_P = (per == 16'd0) ? 1 : int'(per);
                m_B = bud; m_cnt = 32'd0; m_stall = 0; m_ovr = 1'b0; m_perr = 1'b0;
                m_done = 1'b0; m_pend = 1'b0; m_wait = 0; m_active = 1'b1;
                m_left = m_P - 1;
                m_req = (m_left == 0);
            end
        end else if (m_req) begin
            if (sp) m_pend = 1'b1;
            if (a) begin
                m_cnt = m_cnt + 32'd1;
                m_req = 1'b0;
                if (m_pend) m_active = 1'b0;
                else if (m_B != 32'd0 && m_cnt == m_B) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end else m_left = m_P;
                m_pend = 1'b0;
            end else begin
                if (m_stall < 64'hFFFF_FFFF) m_stall++;
                m_wait++;
                if (m_wait >= m_P) m_ovr = 1'b1;
            end
        end else begin
            if (sp) m_active = 1'b0;
            else if (!pa) begin
                m_left--;
                if (m_left == 0) begin
                    m_req = 1'b1;
                    m_wait = 0;
                end
            end
        end
        if (a && !req_was) m_perr = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[21];
        bit   hit;

        // Tied-ack runs: P=4,B=3 then P=0(->1),B=2; row i expects cycle i+1.
        vecs[0]  = mk(1, 0, 0, 1, 16'd4, 32'd3, 0, 1, 0, 32'd0);
        vecs[1]  = mk(0, 0, 0, 1, 16'd4, 32'd3, 0, 1, 0, 32'd0);
        vecs[2]  = mk(0, 0, 0, 1, 16'd4, 32'd3, 0, 1, 0, 32'd0);
        vecs[3]  = mk(0, 0, 0, 1, 16'd4, 32'd3, 1, 1, 0, 32'd0);
        vecs[4]  = mk(0, 0, 0, 1, 16'd4, 32'd3, 0, 1, 0, 32'd1);
        vecs[5]  = mk(0, 0, 0, 1, 16'd4, 32'd3, 0, 1, 0, 32'd1);
        vecs[6]  = mk(0, 0, 0, 1, 16'd4, 32'd3, 0, 1, 0, 32'd1);
        vecs[7]  = mk(0, 0, 0, 1, 16'd4, 32'd3, 0, 1, 0, 32'd1);
        vecs[8]  = mk(0, 0, 0, 1, 16'd4, 32'd3, 1, 1, 0, 32'd1);
        vecs[9]  = mk(0, 0, 0, 1, 16'd4, 32'd3, 0, 1, 0, 32'd2);
        vecs[10] = mk(0, 0, 0, 1, 16'd4, 32'd3, 0, 1, 0, 32'd2);
        vecs[11] = mk(0, 0, 0, 1, 16'd4, 32'd3, 0, 1, 0, 32'd2);
        vecs[12] = mk(0, 0, 0, 1, 16'd4, 32'd3, 0, 1, 0, 32'd2);
        vecs[13] = mk(0, 0, 0, 1, 16'd4, 32'd3, 1, 1, 0, 32'd2);
        vecs[14] = mk(0, 0, 0, 1, 16'd4, 32'd3, 0, 0, 1, 32'd3);
        vecs[15] = mk(0, 0, 0, 1, 16'd4, 32'd3, 0, 0, 1, 32'd3);
        vecs[16] = mk(1, 0, 0, 1, 16'd0, 32'd2, 1, 1, 0, 32'd0);
        vecs[17] = mk(0, 0, 0, 1, 16'd0, 32'd2, 0, 1, 0, 32'd1);
        vecs[18] = mk(0, 0, 0, 1, 16'd0, 32'd2, 1, 1, 0, 32'd1);
        vecs[19] = mk(0, 0, 0, 1, 16'd0, 32'd2, 0, 0, 1, 32'd2);
        vecs[20] = mk(0, 0, 0, 1, 16'd0, 32'd2, 0, 0, 1, 32'd2);

        // Reset state.
        quiet();
        cfg_period = 16'd0; cfg_budget = 32'd0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_req", 32'(tick_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", tick_count, 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);
        chk("rst_flags", {30'd0, overrun, proto_err}, 32'd0);
        rst = 1'b0;
        tick();

        // Ack pulse while idle, then a start clears the error.
        tick_ack = 1'b1;
        tick();
        tick_ack = 1'b0;
        chk("idle_ack_perr", 32'(proto_err), 32'd1);
        chk("idle_ack_count", tick_count, 32'd0);
        chk("idle_ack_busy", 32'(busy), 32'd0);
        cfg_period = 16'd2; cfg_budget = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clr_perr", 32'(proto_err), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        tick();
        chk("p2_req", 32'(tick_req), 32'd1);
        tick_ack = 1'b1;
        tick();
        tick_ack = 1'b0;
        chk("p2_done", 32'(done), 32'd1);

        // Table-driven tied-ack runs.
        for (int i = 0; i < 21; i++) begin
            start = vecs[i].s; stop = vecs[i].sp; pause = vecs[i].pa; tick_ack = vecs[i].a;
            cfg_period = vecs[i].per; cfg_budget = vecs[i].bud;
            tick();
            chk($sformatf("vec%0d_req", i), 32'(tick_req), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d_count", i), tick_count, vecs[i].e_cnt);
        end
        quiet();
        chk("tied_ack_stall", stall_cycles, 32'd0);
        chk("tied_ack_overrun", 32'(overrun), 32'd0);

        // Stalled handshake: P=3, B=1, ack 5 cycles after request rises.
        cfg_period = 16'd3; cfg_budget = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("stall_req_c2", 32'(tick_req), 32'd0);
        tick();
        chk("stall_req_c3", 32'(tick_req), 32'd1);
        for (int c = 4; c <= 8; c++) tick();
        chk("stall_req_c8", 32'(tick_req), 32'd1);
        tick_ack = 1'b1;
        tick();
        tick_ack = 1'b0;
        chk("stall_req_low", 32'(tick_req), 32'd0);
        chk("stall_cycles", stall_cycles, 32'd5);
        chk("stall_overrun", 32'(overrun), 32'd1);
        chk("stall_count", tick_count, 32'd1);
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_busy", 32'(busy), 32'd0);

        // Pause in WAIT, then stop while the request is pending.
        cfg_period = 16'd5; cfg_budget = 32'd0; start = 1'b1;
        tick();                       // cycle 0
        start = 1'b0;
        tick();                       // cycle 1
        pause = 1'b1;
        tick(); tick(); tick();       // cycles 2..4 paused
        pause = 1'b0;
        tick(); tick();               // cycles 5,6
        chk("pause_req_c7", 32'(tick_req), 32'd0);
        tick();
        chk("pause_req_c8", 32'(tick_req), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_req_held", 32'(tick_req), 32'd1);
        tick(); tick();
        chk("stop_req_c11", 32'(tick_req), 32'd1);
        tick_ack = 1'b1;
        tick();
        tick_ack = 1'b0;
        chk("stop_req_low", 32'(tick_req), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        chk("stop_count", tick_count, 32'd1);
        chk("stop_stall", stall_cycles, 32'd3);
        chk("stop_overrun", 32'(overrun), 32'd0);
        tick(); tick();
        chk("stop_idle_busy", 32'(busy), 32'd0);
        chk("stop_idle_req", 32'(tick_req), 32'd0);

        // Reset mid-run while a request is pending with tick_count=2.
        cfg_period = 16'd2; cfg_budget = 32'd0; start = 1'b1; tick_ack = 1'b1;
        tick();
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (tick_count == 32'd2) hit = 1'b1;
            else tick();
        end
        if (!hit) chk("rstmid_count_timeout", 32'd0, 32'd1);
        tick_ack = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (tick_req) hit = 1'b1;
            else tick();
        end
        if (!hit) chk("rstmid_req_timeout", 32'd0, 32'd1);
        chk("rstmid_pre_count", tick_count, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_req", 32'(tick_req), 32'd0);
        chk("rstmid_count", tick_count, 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        cfg_period = 16'd1; cfg_budget = 32'd1; start = 1'b1; tick_ack = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_req", 32'(tick_req), 32'd1);
        tick();
        tick_ack = 1'b0;
        chk("post_rst_done", 32'(done), 32'd1);
        chk("post_rst_count", tick_count, 32'd1);

        // Randomized run against the behavioural model.
        rst = 1'b1;
        quiet();
        tick();
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            start      = ($urandom_range(0, 15) == 0);
            stop       = ($urandom_range(0, 40) == 0);
            pause      = ($urandom_range(0, 3) == 0);
            tick_ack   = ($urandom_range(0, 2) == 0);
            cfg_period = 16'($urandom_range(0, 6));
            cfg_budget = 32'($urandom_range(0, 4));
            @(posedge clk);
            model_step(start, stop, pause, tick_ack, cfg_period, cfg_budget);
            #1;
            chk($sformatf("rnd%0d_req", n), 32'(tick_req), 32'(m_req));
            chk($sformatf("rnd%0d_busy", n), 32'(busy), 32'(m_active));
            chk($sformatf("rnd%0d_done", n), 32'(done), 32'(m_done));
            chk($sformatf("rnd%0d_count", n), tick_count, m_cnt);
            chk($sformatf("rnd%0d_stall", n), stall_cycles, 32'(m_stall));
            chk($sformatf("rnd%0d_ovr", n), 32'(overrun), 32'(m_ovr));
            chk($sformatf("rnd%0d_perr", n), 32'(proto_err), 32'(m_perr));
        end
        quiet();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
